// File: rtl/imu_burst_reader_pkg.sv
// Shared definitions for the ICM-42688-P burst reader.
//
// Contents:
//   - sensor register addresses and the SPI read flag
//   - burst length and shadow byte-index to field mapping
//   - burst FSM state encoding
//   - burst_word(): extracts a big-endian 16-bit field from the byte buffer
//
// Optional build macro used by the reader: IMU_DRDY_EN (see imu_burst_reader.sv).

package imu_pkg;

    localparam logic [7:0] REG_TEMP_DATA1   = 8'h1D;
    localparam logic [7:0] REG_GYRO_DATA_Z0 = 8'h2A;
    localparam logic [7:0] SPI_READ_FLAG    = 8'h80;
    localparam logic [7:0] BURST_CMD        = SPI_READ_FLAG | REG_TEMP_DATA1;

    localparam int unsigned BURST_LEN = 14;

    typedef logic [3:0]                 byte_idx_t;
    typedef logic [BURST_LEN-1:0][7:0]  burst_t;

    // The burst covers a contiguous register block, so the last index follows from the addresses.
    localparam byte_idx_t IDX_LAST = byte_idx_t'(REG_GYRO_DATA_Z0 - REG_TEMP_DATA1);

    // Index of the high byte of each field; the low byte follows at index + 1.
    localparam byte_idx_t IDX_TEMP    = 4'd0;
    localparam byte_idx_t IDX_ACCEL_X = 4'd2;
    localparam byte_idx_t IDX_ACCEL_Y = 4'd4;
    localparam byte_idx_t IDX_ACCEL_Z = 4'd6;
    localparam byte_idx_t IDX_GYRO_X  = 4'd8;
    localparam byte_idx_t IDX_GYRO_Y  = 4'd10;
    localparam byte_idx_t IDX_GYRO_Z  = 4'd12;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StCommit
    } imu_state_e;

    function automatic logic [15:0] burst_word(input burst_t b, input byte_idx_t hi);
        return {b[hi], b[hi + byte_idx_t'(1)]};
    endfunction

endpackage

// File: rtl/imu_burst_reader_if.sv
// Byte-level SPI master handshake between the burst reader and the SPI shifter.
//
// Signals:
//   spi_start  one-cycle pulse: start one byte transfer
//   spi_tx     byte to shift out, valid while spi_start is high
//   spi_csn    chip select, active low, held for a whole burst
//   spi_done   one-cycle pulse: byte transfer complete
//   spi_rx     received byte, valid while spi_done is high
// Modports: master (burst reader), slave (SPI shifter / model).

interface imu_burst_reader_if;

    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_csn;
    logic       spi_done;
    logic [7:0] spi_rx;

    modport master (
        output spi_start,
        output spi_tx,
        output spi_csn,
        input  spi_done,
        input  spi_rx
    );

    modport slave (
        input  spi_start,
        input  spi_tx,
        input  spi_csn,
        output spi_done,
        output spi_rx
    );

endinterface

// File: rtl/imu_burst_reader_sample_tick.sv
// Burst trigger source for the IMU burst reader.
//
// Default build: divides clk_i by CLK_HZ/SAMPLE_HZ; the counter runs 0..period-1 and tick_o
// pulses on the wrap cycle. The counter is held at 0 while enable_i is low.
// With IMU_DRDY_EN defined: int1_i (sensor data-ready) is synchronised with two flops and
// tick_o pulses on its rising edge; CLK_HZ/SAMPLE_HZ are then unused.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   enable_i       ticks allowed only while high
//   int1_i         data-ready input (IMU_DRDY_EN only)
//   tick_o         one-cycle trigger pulse

module imu_sample_tick #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_HZ = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
`ifdef IMU_DRDY_EN
    input  logic int1_i,
`endif
    output logic tick_o
);

`ifdef IMU_DRDY_EN

    // [0],[1]: synchroniser; [2]: previous synchronised value for edge detect.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], int1_i};
        end
    end

    assign tick_o = enable_i && sync_q[1] && !sync_q[2];

`else

    localparam int unsigned Period = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    assign wrap = (cnt_q == CntW'(Period - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && wrap;

`endif

endmodule

// File: rtl/imu_burst_reader.sv
// ICM-42688-P burst reader: on each sample trigger, reads TEMP_DATA1..GYRO_DATA_Z0 (14 bytes)
// over a byte-level SPI handshake, assembles seven signed 16-bit samples in a shadow buffer
// and publishes them all at once with a one-cycle data_valid_o pulse.
//
// Build option: IMU_DRDY_EN -- trigger on the rising edge of int1_i instead of the timer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   int1_i               sensor data-ready (IMU_DRDY_EN only)
//   enable_i             IMU init complete; bursts run only while high
//   spi                  SPI byte handshake (master modport)
//   temp_o, accel_*_o,
//   gyro_*_o             signed samples, held until the next complete burst
//   data_valid_o         one-cycle pulse when a new sample set is published
//   error_o              last burst aborted on byte timeout

module imu_burst_reader
    import imu_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SAMPLE_HZ   = 100,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
`ifdef IMU_DRDY_EN
    input  logic                int1_i,
`endif
    input  logic                enable_i,
    imu_burst_reader_if.master  spi,
    output logic signed [15:0]  accel_x_o,
    output logic signed [15:0]  accel_y_o,
    output logic signed [15:0]  accel_z_o,
    output logic signed [15:0]  gyro_x_o,
    output logic signed [15:0]  gyro_y_o,
    output logic signed [15:0]  gyro_z_o,
    output logic signed [15:0]  temp_o,
    output logic                data_valid_o,
    output logic                error_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;

    logic tick;

    imu_sample_tick #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_sample_tick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
`ifdef IMU_DRDY_EN
        .int1_i   (int1_i),
`endif
        .tick_o   (tick)
    );

    imu_state_e      state_q, state_d;
    logic            issued_q, issued_d;  // byte in flight: start sent, done not yet seen
    byte_idx_t       idx_q, idx_d;
    logic [TmoW-1:0] tmo_q, tmo_d;        // cycles since the last spi_start
    logic            csn_q, csn_d;
    logic            err_q, err_d;
    burst_t          shadow_q, shadow_d;
    burst_t          out_q, out_d;
    logic            start;

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        csn_d    = csn_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        start    = 1'b0;

        unique case (state_q)
            StIdle: begin
                csn_d    = 1'b1;
                issued_d = 1'b0;
                if (tick && enable_i) begin
                    csn_d   = 1'b0;
                    state_d = StCmd;
                end
            end

            StCmd, StData: begin
                if (!enable_i) begin
                    // Init lost: drop the burst silently, leave error_o alone.
                    csn_d    = 1'b1;
                    issued_d = 1'b0;
                    state_d  = StIdle;
                end else if (!issued_q) begin
                    start    = 1'b1;
                    issued_d = 1'b1;
                    tmo_d    = TmoW'(1);
                end else if (spi.spi_done) begin
                    issued_d = 1'b0;
                    if (state_q == StCmd) begin
                        idx_d   = '0;
                        state_d = StData;
                    end else begin
                        shadow_d[idx_q] = spi.spi_rx;
                        if (idx_q == IDX_LAST) begin
                            // Publish on entry to commit so outputs and the valid pulse line up.
                            out_d   = shadow_d;
                            err_d   = 1'b0;
                            csn_d   = 1'b1;
                            state_d = StCommit;
                        end else begin
                            idx_d = idx_q + byte_idx_t'(1);
                        end
                    end
                end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    err_d    = 1'b1;
                    csn_d    = 1'b1;
                    issued_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end

            StCommit: begin
                state_d = StIdle;
            end

            default: begin
                csn_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            issued_q <= 1'b0;
            idx_q    <= '0;
            tmo_q    <= '0;
            csn_q    <= 1'b1;
            err_q    <= 1'b0;
            shadow_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            csn_q    <= csn_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign spi.spi_start = start;
    assign spi.spi_tx    = (state_q == StCmd) ? BURST_CMD : 8'h00;
    assign spi.spi_csn   = csn_q;

    assign data_valid_o = (state_q == StCommit);
    assign error_o      = err_q;

    assign temp_o    = burst_word(out_q, IDX_TEMP);
    assign accel_x_o = burst_word(out_q, IDX_ACCEL_X);
    assign accel_y_o = burst_word(out_q, IDX_ACCEL_Y);
    assign accel_z_o = burst_word(out_q, IDX_ACCEL_Z);
    assign gyro_x_o  = burst_word(out_q, IDX_GYRO_X);
    assign gyro_y_o  = burst_word(out_q, IDX_GYRO_Y);
    assign gyro_z_o  = burst_word(out_q, IDX_GYRO_Z);

endmodule

// File: tb/tb_imu_burst_reader.sv
// Directed bench for imu_burst_reader (timer build). Trigger period 100 cycles, SPI model
// answers each byte 8 cycles after spi_start, so a burst (~137 cycles) outlasts one period.

module tb_imu_burst_reader;

    localparam int unsigned CLK_HZ      = 1000;
    localparam int unsigned SAMPLE_HZ   = 10;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int          SPI_DLY     = 8;

    logic        clk_i    = 1'b0;
    logic        rst_ni   = 1'b0;
    logic        enable_i = 1'b0;
    logic [15:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z, temp;
    logic        data_valid, error;

    imu_burst_reader_if spi_bus ();

    imu_burst_reader #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_HZ   (SAMPLE_HZ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .spi          (spi_bus),
        .accel_x_o    (accel_x),
        .accel_y_o    (accel_y),
        .accel_z_o    (accel_z),
        .gyro_x_o     (gyro_x),
        .gyro_y_o     (gyro_y),
        .gyro_z_o     (gyro_z),
        .temp_o       (temp),
        .data_valid_o (data_valid),
        .error_o      (error)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // SPI slave model and monitors (all at negedge, away from the active edge).
    logic [7:0]  rx_tab [14];
    int          mute_no = -1;
    int          cnt_left = 0, byte_no = 0, done_no = -1;
    int          start_cnt = 0, cmd_cnt = 0, bad_tx_cnt = 0;
    int          dv_cnt = 0, dv_wide = 0, dv_csn_bad = 0, csn_fall = 0;
    int unsigned mute_start_cyc = 0, last_done_cyc = 0, dv_cyc = 0, csn_fall_cyc = 0;
    logic        dv_prev = 1'b0, csn_prev = 1'b1;

    always @(negedge clk_i) begin
        spi_bus.spi_done = 1'b0;
        if (cnt_left > 0) begin
            cnt_left--;
            if (cnt_left == 0 && byte_no != mute_no) begin
                spi_bus.spi_done = 1'b1;
                spi_bus.spi_rx   = (byte_no == 0 || byte_no > 14) ? 8'hA5 : rx_tab[byte_no-1];
                done_no          = byte_no;
                last_done_cyc    = cyc;
            end
        end
        if (spi_bus.spi_start === 1'b1) begin
            start_cnt++;
            if (spi_bus.spi_tx == 8'h9D) begin
                cmd_cnt++;
                byte_no = 0;
            end else begin
                if (spi_bus.spi_tx != 8'h00) bad_tx_cnt++;
                byte_no++;
            end
            if (byte_no == mute_no) mute_start_cyc = cyc;
            cnt_left = SPI_DLY;
        end
        if (data_valid === 1'b1) begin
            dv_cnt++;
            dv_cyc = cyc;
            if (spi_bus.spi_csn !== 1'b1) dv_csn_bad++;
            if (dv_prev === 1'b1) dv_wide++;
        end
        if (csn_prev === 1'b1 && spi_bus.spi_csn === 1'b0) begin
            csn_fall++;
            csn_fall_cyc = cyc;
        end
        dv_prev  = data_valid;
        csn_prev = spi_bus.spi_csn;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the posedge that ends the data_valid cycle, plus #1.
    task automatic wait_dv(input int max_cyc, output bit ok);
        int snap;
        snap = dv_cnt;
        ok   = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk_i);
            if (dv_cnt != snap) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_done_no(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk_i);
            if (spi_bus.spi_done === 1'b1 && done_no == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit          ok;
        int unsigned rel_cyc;
        int          snap_start, snap_dv, snap_fall;

        for (int i = 0; i < 14; i++) rx_tab[i] = 8'(i + 1);

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_csn", spi_bus.spi_csn, 1);
        check("rst_start", spi_bus.spi_start, 0);
        check("rst_tx", spi_bus.spi_tx, 0);
        check("rst_valid", data_valid, 0);
        check("rst_error", error, 0);
        check("rst_temp", temp, 0);
        check("rst_gyro_z", gyro_z, 0);

        // Burst 1: bytes 0x01..0x0E.
        @(negedge clk_i);
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        rel_cyc  = cyc;
        wait_dv(400, ok);
        check("b1_seen", ok, 1);
        check("b1_first_latency", csn_fall_cyc - rel_cyc, 100);
        check("b1_temp", temp, 16'h0102);
        check("b1_accel_x", accel_x, 16'h0304);
        check("b1_accel_y", accel_y, 16'h0506);
        check("b1_accel_z", accel_z, 16'h0708);
        check("b1_gyro_x", gyro_x, 16'h090A);
        check("b1_gyro_y", gyro_y, 16'h0B0C);
        check("b1_gyro_z", gyro_z, 16'h0D0E);
        check("b1_valid_after_done", dv_cyc - last_done_cyc, 1);
        check("b1_valid_width", data_valid, 0);
        check("b1_csn_with_valid", dv_csn_bad, 0);
        check("b1_starts", start_cnt, 15);
        check("b1_cmd_bytes", cmd_cnt, 1);
        check("b1_error", error, 0);

        // Burst 2: negative accel_x; mid-burst ticks must be dropped.
        rx_tab[2] = 8'hFF;
        rx_tab[3] = 8'h38;
        wait_dv(400, ok);
        check("b2_seen", ok, 1);
        check("b2_accel_x", accel_x, 16'hFF38);
        check("b2_accel_x_signed", $signed(accel_x), -200);
        check("b2_temp", temp, 16'h0102);
        check("b2_dv_count", dv_cnt, 2);
        check("b2_bursts", csn_fall, 2);
        check("b2_starts", start_cnt, 30);
        repeat (60) @(posedge clk_i);
        #1;
        check("b2_hold_accel_x", accel_x, 16'hFF38);
        check("b2_hold_gyro_z", gyro_z, 16'h0D0E);

        // Timeout: data byte index 5 never answered.
        wait_dv(400, ok);
        check("b3_seen", ok, 1);
        mute_no = 6;
        snap_dv = dv_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #1;
            if (error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_error_seen", ok, 1);
        check("tmo_latency", cyc - mute_start_cyc, TIMEOUT_CYC);
        check("tmo_csn", spi_bus.spi_csn, 1);
        check("tmo_no_valid", dv_cnt, snap_dv);
        check("tmo_hold_accel_x", accel_x, 16'hFF38);
        mute_no = -1;
        wait_dv(400, ok);
        check("retry_seen", ok, 1);
        check("retry_error_clear", error, 0);
        check("retry_accel_x", accel_x, 16'hFF38);

        // enable_i dropped after the 7th data byte.
        wait_done_no(7, 400, ok);
        check("drop_reached", ok, 1);
        #1;
        enable_i   = 1'b0;
        snap_start = start_cnt;
        snap_dv    = dv_cnt;
        check("drop_csn_before", spi_bus.spi_csn, 0);
        @(posedge clk_i);
        #1;
        check("drop_csn_after", spi_bus.spi_csn, 1);
        check("drop_error", error, 0);
        snap_fall = csn_fall;
        repeat (250) @(posedge clk_i);
        #1;
        check("drop_no_start", start_cnt, snap_start);
        check("drop_no_valid", dv_cnt, snap_dv);
        check("drop_no_csn", csn_fall, snap_fall);
        enable_i = 1'b1;
        rel_cyc  = cyc;
        wait_dv(400, ok);
        check("reen_seen", ok, 1);
        check("reen_latency", csn_fall_cyc - rel_cyc, 100);
        check("reen_dv_count", dv_cnt, snap_dv + 1);
        check("reen_gyro_y", gyro_y, 16'h0B0C);

        // Asynchronous reset in the middle of DATA.
        wait_done_no(3, 400, ok);
        check("rst2_reached", ok, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rst2_csn", spi_bus.spi_csn, 1);
        check("rst2_start", spi_bus.spi_start, 0);
        check("rst2_temp", temp, 0);
        check("rst2_accel_x", accel_x, 0);
        check("rst2_valid", data_valid, 0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        rel_cyc = cyc;
        wait_dv(400, ok);
        check("rst2_burst_seen", ok, 1);
        check("rst2_latency", csn_fall_cyc - rel_cyc, 100);
        check("rst2_accel_x_new", accel_x, 16'hFF38);

        check("valid_width_all", dv_wide, 0);
        check("csn_with_valid_all", dv_csn_bad, 0);
        check("tx_bytes_all", bad_tx_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
